// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - shared core types and constants
package riscv_cpu_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam int          IMEM_MAX_LATENCY = 8;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } imem_resp_t;

  localparam int IMEM_RESP_W = $bits(imem_resp_t);

endpackage

// File: rtl/imem_delay_line.sv
// rtl/imem_delay_line.sv - fixed-depth shift register carrying fetch responses
module imem_delay_line
  import riscv_cpu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [IMEM_RESP_W-1:0] resp_d,
  output logic [IMEM_RESP_W-1:0] resp_q
);

  imem_resp_t stage_q [DEPTH];
  imem_resp_t head;

  assign head = resp_d;

  // Empty slots carry all-zero payload so rdata/err read 0 whenever valid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= head.valid ? head : '0;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign resp_q = stage_q[DEPTH-1];

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - instruction memory responding to fetch requests with fixed latency
module instr_mem_responder
  import riscv_cpu_pkg::*;
#(
  parameter int          MEM_DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        stall_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      mem_q [MEM_DEPTH];
  logic [CNT_W-1:0] outstanding_q;
  logic [31:0]      fetch_off;
  logic [31:0]      load_off;
  logic             fetch_err;
  logic             load_ok;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_idx;
  imem_resp_t       resp_d;
  imem_resp_t       resp_q;

  // Offsets below BASE_ADDR wrap high, so one upper-bits test covers both range limits.
  assign fetch_off = instr_addr_i - BASE_ADDR;
  assign fetch_err = (fetch_off[1:0] != 2'b00) || (fetch_off[31:IDX_W+2] != '0);
  assign fetch_idx = fetch_off[IDX_W+1:2];

  assign load_off  = load_addr_i - BASE_ADDR;
  assign load_ok   = load_we_i && (load_off[1:0] == 2'b00) && (load_off[31:IDX_W+2] == '0);
  assign load_idx  = load_off[IDX_W+1:2];

  assign instr_gnt_o = instr_req_i && !stall_i && (outstanding_q < CNT_W'(MAX_OUTSTANDING));

  // Write lands at the edge, so a grant in the same cycle captures the old word.
  always_ff @(posedge clk_i) begin
    if (load_ok) begin
      mem_q[load_idx] <= load_wdata_i;
    end
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = instr_gnt_o;
    resp_d.err   = fetch_err;
    resp_d.rdata = fetch_err ? INSTR_NOP : mem_q[fetch_idx];
  end

  imem_delay_line #(
    .DEPTH (LATENCY)
  ) u_delay_line (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .resp_d (resp_d),
    .resp_q (resp_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else if (instr_gnt_o && !resp_q.valid) begin
      outstanding_q <= outstanding_q + CNT_W'(1);
    end else if (!instr_gnt_o && resp_q.valid) begin
      outstanding_q <= outstanding_q - CNT_W'(1);
    end
  end

  assign instr_rvalid_o = resp_q.valid;
  assign instr_err_o    = resp_q.err;
  assign instr_rdata_o  = resp_q.rdata;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - scoreboard bench driving LATENCY=1 and LATENCY=3 responders in parallel
module tb_instr_mem_responder;
  import riscv_cpu_pkg::*;

  localparam int DEPTH = 64;
  localparam int MO    = 2;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        stall = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_wdata = '0;
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata [2];

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] mem_m [DEPTH];
  int          out_m [2];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(
    .MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(MO)
  ) dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
    .instr_err_o(err[0]), .stall_i(stall), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata)
  );

  instr_mem_responder #(
    .MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(MO)
  ) dut_l3 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
    .instr_err_o(err[1]), .stall_i(stall), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input int id);
    return (id == 0) ? 1 : 3;
  endfunction

  function automatic exp_t fetch_exp(input int due);
    exp_t x;
    x.due = due;
    if (addr[1:0] != 2'b00 || addr >= 32'(DEPTH * 4)) begin
      x.data = INSTR_NOP;
      x.err  = 1'b1;
    end else begin
      x.data = mem_m[addr / 4];
      x.err  = 1'b0;
    end
    return x;
  endfunction

  task automatic mon(input int id, input logic g, input logic v, input logic [31:0] d, input logic e);
    exp_t hd;
    int   n;
    logic v_exp;
    logic g_exp;
    n = (id == 0) ? sb0.size() : sb1.size();
    v_exp = 1'b0;
    if (n > 0) begin
      hd = (id == 0) ? sb0[0] : sb1[0];
      v_exp = (hd.due == cyc);
    end
    check_eq($sformatf("rvalid_l%0d", lat_of(id)), 32'(v), 32'(v_exp));
    if (v_exp) begin
      check_eq($sformatf("rdata_l%0d", lat_of(id)), d, hd.data);
      check_eq($sformatf("err_l%0d", lat_of(id)), 32'(e), 32'(hd.err));
      if (id == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
    end else begin
      check_eq($sformatf("idle_rdata_l%0d", lat_of(id)), d, 32'h0);
      check_eq($sformatf("idle_err_l%0d", lat_of(id)), 32'(e), 32'h0);
    end
    g_exp = req && !stall && (out_m[id] < MO);
    check_eq($sformatf("gnt_l%0d", lat_of(id)), 32'(g), 32'(g_exp));
    if (g_exp) begin
      if (id == 0) sb0.push_back(fetch_exp(cyc + lat_of(id)));
      else         sb1.push_back(fetch_exp(cyc + lat_of(id)));
    end
    out_m[id] = out_m[id] + int'(g_exp) - int'(v_exp);
  endtask

  // Model memory updates after both monitors sample, mirroring read-before-write.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb0.delete();
      sb1.delete();
      out_m = '{0, 0};
      for (int i = 0; i < 2; i++) begin
        check_eq("rst_rvalid", 32'(rvalid[i]), 32'h0);
        check_eq("rst_rdata", rdata[i], 32'h0);
        check_eq("rst_err", 32'(err[i]), 32'h0);
      end
    end else begin
      mon(0, gnt[0], rvalid[0], rdata[0], err[0]);
      mon(1, gnt[1], rvalid[1], rdata[1], err[1]);
      if (load_we && load_addr[1:0] == 2'b00 && load_addr < 32'(DEPTH * 4))
        mem_m[load_addr / 4] = load_wdata;
    end
    cyc++;
  end

  task automatic drive(input logic r, input logic [31:0] a, input logic s,
                       input logic we, input logic [31:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    req = r; addr = a; stall = s; load_we = we; load_addr = la; load_wdata = ld;
  endtask

  task automatic fetch(input logic [31:0] a);
    drive(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 32'h0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    load(32'h0, 32'h0010_0093);
    load(32'h4, 32'h0020_0113);
    load(32'h8, 32'h0030_0193);
    load(32'hC, 32'h0040_0213);
    load(32'h10, 32'hCAFE_0004);
    idle(1);
    // back-to-back fetches
    fetch(32'h0); fetch(32'h4);
    idle(5);
    // third request waits for a free slot on the LATENCY=3 responder
    fetch(32'h0); fetch(32'h4);
    for (int i = 0; i < 4; i++) fetch(32'h8);
    idle(6);
    // misaligned and out-of-range fetches
    fetch(32'h2); idle(1);
    fetch(32'(DEPTH * 4)); fetch(32'hFFFF_FFFC);
    idle(6);
    // load conflicting with a fetch of the same word, then dropped loads
    drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    idle(4);
    fetch(32'h10);
    idle(4);
    load(32'h11, 32'h1234_5678);
    load(32'(DEPTH * 4), 32'hBAD0_BAD0);
    fetch(32'h10); fetch(32'h0);
    idle(6);
    // stall with requests in flight
    fetch(32'h4); fetch(32'h8);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hC, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(6);
    @(negedge clk);
    check_eq("cnt_after_stall_l1", 32'(dut_l1.outstanding_q), 32'h0);
    check_eq("cnt_after_stall_l3", 32'(dut_l3.outstanding_q), 32'h0);
    // reset while LATENCY=3 has two requests in flight
    fetch(32'h0); fetch(32'h4);
    @(posedge clk);
    #1 rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    check_eq("cnt_in_rst_l3", 32'(dut_l3.outstanding_q), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);
    fetch(32'h0);
    idle(6);
    @(negedge clk);
    check_eq("drain_l1", 32'(sb0.size()), 32'h0);
    check_eq("drain_l3", 32'(sb1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Responder end of the core's instruction-fetch interface. It accepts req/addr from the fetch stage, grants requests under an outstanding-transaction limit, and returns rdata/rvalid after a fixed, parameterised latency. It serves as the instruction memory model and the FPGA boot ROM/RAM. A side load port fills program contents before or while the core runs.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words (power of two, >=2)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (MEM_DEPTH*4 aligned)
LATENCY, 1, cycles from grant to rvalid (1..8)
MAX_OUTSTANDING, 2, max granted-but-not-returned requests (1..LATENCY+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request valid
instr_addr_i  in  32  fetch byte address
instr_gnt_o  out  1  request accepted this cycle (combinational)
instr_rvalid_o  out  1  response valid, one cycle per granted request
instr_rdata_o  out  32  fetched instruction word
instr_err_o  out  1  response error (misaligned or out of range), qualified by rvalid
stall_i  in  1  backpressure injection; forces gnt low
load_we_i  in  1  load-port word write enable
load_addr_i  in  32  load-port byte address
load_wdata_i  in  32  load-port write data

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i.
- Reset values: rvalid_o=0, rdata_o=0, err_o=0, outstanding counter=0, delay line empty. The memory array is not reset, so its contents survive reset.
- Grant: gnt_o = req_i & ~stall_i & (outstanding_q < MAX_OUTSTANDING). The same-cycle rvalid does not free a slot, so there is no combinational path from the pipe to gnt.
- Accepted request (gnt=1 at cycle t):
  - The memory word is read in cycle t.
  - The data is carried through a LATENCY-deep delay line.
  - rvalid_o=1 with rdata/err in cycle t+LATENCY.
  - Responses return strictly in order, one per grant, with no gaps inserted.
- Outstanding counter: next = q + gnt - rvalid. Width is clog2(MAX_OUTSTANDING+1). It never exceeds MAX_OUTSTANDING and never underflows.
- Address decode:
  - Word index = (addr - BASE_ADDR)[clog2(MEM_DEPTH)+1:2].
  - Error if addr[1:0] != 0, or addr < BASE_ADDR, or addr >= BASE_ADDR + MEM_DEPTH*4.
  - On error, the request is still granted. Response: rdata = NOP (32'h0000_0013), err=1. Memory is not accessed.
- When rvalid_o=0: rdata_o and err_o hold 0 (the delay line clears the data when the valid bit is clear).
- Load port:
  - Word write when load_we_i=1 and the address is aligned and in range. Otherwise the write is silently dropped.
  - Takes effect at the clock edge.
  - A same-cycle fetch grant to the same word returns OLD data (read-before-write).
- Simultaneous grant and rvalid: the counter is unchanged.
- req_i deasserted while requests are outstanding: in-flight responses still complete.
- stall_i high: no new grants. In-flight responses continue.
- Reset mid-operation: the delay line and counter clear immediately. In-flight responses are dropped, and no rvalid is produced after reset release until a new grant.
- The requester must hold addr stable only in the grant cycle. No address buffering is required beyond that cycle.

Decomposition:
- Add to riscv_cpu_pkg:
  - INSTR_NOP constant (32'h0000_0013)
  - imem_resp_t struct {valid, err, rdata[31:0]}
  - IMEM_MAX_LATENCY = 8
- Sub-module imem_delay_line: LATENCY-stage shift register of imem_resp_t. Parameter DEPTH. Async reset clears all valid bits and data.
- The memory array is an inferred single-clock array with one read port and one write port. It lives in the top module.

Test Plan:
1. LATENCY=1, MAX_OUTSTANDING=2: preload word0=32'h0010_0093, word1=32'h0020_0113; req held high with addr 0x0 then 0x4 -> gnt every cycle; rvalid in cycles t+1 and t+2 with those words; err=0.
2. LATENCY=3, MAX_OUTSTANDING=2: req held high with addresses 0x0, 0x4, 0x8 -> gnt 1,1,0 (third request granted only after the first rvalid frees a slot); responses in order with no gaps.
3. Error cases: addr 0x2 -> gnt=1, rvalid with rdata=32'h0000_0013, err=1. addr = BASE_ADDR + MEM_DEPTH*4 -> same response.
4. Load conflict: load_we_i writes 32'hDEAD_BEEF to 0x10 in the same cycle a fetch to 0x10 is granted -> response carries old data; a next fetch of 0x10 returns 32'hDEAD_BEEF.
5. stall_i asserted for 4 cycles with req high -> gnt=0 throughout; previously granted responses still arrive; the counter returns to 0.
6. LATENCY=3 with two requests in flight, rst_ni pulsed low -> rvalid=0, rdata=0, counter=0; no stale rvalid after release; a new fetch to 0x0 still returns the preloaded word.
